// File: rtl/uart_tx_pkg.sv
// =============================================================================
// Module      : uart_tx_pkg
// Description : Shared constants for the UART TX frame sequencer: the TX mux
//               select encodings, the FSM state codes and the default width.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package uart_tx_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [2:0] MUX_START  = 3'b000;
  localparam logic [2:0] MUX_DATA   = 3'b001;
  localparam logic [2:0] MUX_PARITY = 3'b010;
  localparam logic [2:0] MUX_STOP   = 3'b011;
  localparam logic [2:0] MUX_IDLE   = 3'b111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic logic [2:0] mux_for_state(input logic [2:0] st);
    case (st)
      ST_START:  return MUX_START;
      ST_DATA:   return MUX_DATA;
      ST_PARITY: return MUX_PARITY;
      ST_STOP:   return MUX_STOP;
      default:   return MUX_IDLE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_serializer.sv
// =============================================================================
// Module      : uart_tx_serializer
// Description : Payload shift register and bit counter; presents one data bit
//               per cycle LSB first and flags the last data bit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

import uart_tx_pkg::*;

module uart_tx_serializer #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  prime,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int              CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;

  // prime runs during START so bit 0 is already on ser_data for the first DATA cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      ser_data  <= 1'b0;
    end else if (load) begin
      shift_reg <= data;
      bit_cnt   <= '0;
    end else if (prime) begin
      ser_data  <= shift_reg[0];
      shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
      bit_cnt   <= '0;
    end else if (shift_en) begin
      ser_data  <= shift_reg[0];
      shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

  assign ser_done = (bit_cnt == LAST_BIT);

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// =============================================================================
// Module      : uart_tx_ctrl
// Description : UART TX frame sequencer: start, LSB-first data, optional
//               parity, stop. Drives the TX output mux select.
//               Build option UART_TX_TWO_STOP_EN: two-cycle stop bit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

import uart_tx_pkg::*;

module uart_tx_ctrl #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [2:0]            MUX_SEL,
  output logic                  SER_DATA,
  output logic                  PAR_BIT,
  output logic                  BUSY
);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       accept;
  logic       par_en_q;
  logic       ser_done;

`ifdef UART_TX_TWO_STOP_EN
  logic stop_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stop_cnt <= 1'b0;
    end else if (state == ST_STOP) begin
      stop_cnt <= ~stop_cnt;
    end else begin
      stop_cnt <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (DATA_VALID) begin
          state_nxt = ST_START;
          accept    = 1'b1;
        end
      end
      ST_START:  state_nxt = ST_DATA;
      ST_DATA: begin
        if (ser_done) begin
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: state_nxt = ST_STOP;
      ST_STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (stop_cnt) begin
          state_nxt = ST_IDLE;
        end
`else
        state_nxt = ST_IDLE;
`endif
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      MUX_SEL  <= MUX_IDLE;
      BUSY     <= 1'b0;
      PAR_BIT  <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      MUX_SEL <= mux_for_state(state_nxt);
      BUSY    <= (state_nxt != ST_IDLE);
      if (accept) begin
        PAR_BIT  <= (^P_DATA) ^ PAR_TYP;
        par_en_q <= PAR_EN;
      end
    end
  end

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .prime    (state == ST_START),
    .shift_en (state == ST_DATA),
    .data     (P_DATA),
    .ser_data (SER_DATA),
    .ser_done (ser_done)
  );

endmodule

`default_nettype wire
